// File: rtl/ball_motion_ctrl.sv
// Pong ball motion: serve, wall bounce, paddle reflect with speed ramp, miss scoring.
// One motion step every TICK_DIV cycles; all outputs registered.
module ball_motion_ctrl #(
   parameter int X_W      = 10,
   parameter int Y_W      = 9,
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480,
   parameter int BALL_SZ  = 8,
   parameter int TICK_DIV = 4,
   parameter int SPD_INIT = 1,
   parameter int SPD_MAX  = 4,
   parameter int HOLD_CYC = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           serve,
   input  logic           paddle_l_hit,
   input  logic           paddle_r_hit,
   output logic [X_W-1:0] ball_x,
   output logic [Y_W-1:0] ball_y,
   output logic           x_dir,
   output logic           y_dir,
   output logic [2:0]     speed,
   output logic           score_l,
   output logic           score_r,
   output logic [1:0]     state
);

   localparam int CX   = (SCREEN_W - BALL_SZ) / 2;
   localparam int CY   = (SCREEN_H - BALL_SZ) / 2;
   localparam int XMAX = SCREEN_W - BALL_SZ;
   localparam int YMAX = SCREEN_H - BALL_SZ;
   localparam int TW   = $clog2(TICK_DIV);
   localparam int HW   = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_MOVE = 2'd1, S_SCORED = 2'd2} state_t;

   state_t         state_q, state_d;
   logic [X_W-1:0] ball_x_q, ball_x_d;
   logic [Y_W-1:0] ball_y_q, ball_y_d;
   logic           x_dir_q, x_dir_d, y_dir_q, y_dir_d;
   logic [2:0]     speed_q, speed_d;
   logic           score_l_q, score_l_d, score_r_q, score_r_d;
   logic [TW-1:0]  tick_q, tick_d;
   logic [HW-1:0]  hold_q, hold_d;
   logic           lat_l_q, lat_l_d, lat_r_q, lat_r_d;

   // Position math carries one spare bit so sums never wrap before clamping
   logic [X_W:0] x_ext, spd_x, inc_x, x_plus;
   logic [Y_W:0] y_ext, spd_y, y_plus;
   logic [2:0]   spd_inc;
   logic         eff_l, eff_r, hit;

   always_comb begin
      spd_inc = (speed_q >= 3'(SPD_MAX)) ? 3'(SPD_MAX) : speed_q + 3'd1;
      x_ext   = {1'b0, ball_x_q};
      spd_x   = (X_W+1)'(speed_q);
      inc_x   = (X_W+1)'(spd_inc);
      x_plus  = x_ext + spd_x;
      y_ext   = {1'b0, ball_y_q};
      spd_y   = (Y_W+1)'(speed_q);
      y_plus  = y_ext + spd_y;
      // Only the paddle the ball is travelling toward can return it
      eff_l   = (lat_l_q | paddle_l_hit) & ~x_dir_q;
      eff_r   = (lat_r_q | paddle_r_hit) & x_dir_q;
      hit     = eff_l | eff_r;
   end

   always_comb begin
      state_d   = state_q;
      ball_x_d  = ball_x_q;
      ball_y_d  = ball_y_q;
      x_dir_d   = x_dir_q;
      y_dir_d   = y_dir_q;
      speed_d   = speed_q;
      score_l_d = 1'b0;
      score_r_d = 1'b0;
      tick_d    = tick_q;
      hold_d    = hold_q;
      lat_l_d   = 1'b0;
      lat_r_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            ball_x_d = X_W'(CX);
            ball_y_d = Y_W'(CY);
            speed_d  = 3'(SPD_INIT);
            tick_d   = '0;
            hold_d   = '0;
            if (serve) state_d = S_MOVE;
         end
         S_MOVE: begin
            lat_l_d = lat_l_q | paddle_l_hit;
            lat_r_d = lat_r_q | paddle_r_hit;
            if (tick_q == TW'(TICK_DIV - 1)) begin
               tick_d  = '0;
               lat_l_d = 1'b0;
               lat_r_d = 1'b0;
               if (y_dir_q) begin
                  if (y_plus >= (Y_W+1)'(YMAX)) begin
                     ball_y_d = Y_W'(YMAX);
                     y_dir_d  = 1'b0;
                  end else begin
                     ball_y_d = Y_W'(y_plus);
                  end
               end else if (y_ext <= spd_y) begin
                  ball_y_d = '0;
                  y_dir_d  = 1'b1;
               end else begin
                  ball_y_d = Y_W'(y_ext - spd_y);
               end
               if (hit) begin
                  x_dir_d = ~x_dir_q;
                  speed_d = spd_inc;
                  if (x_dir_q) begin
                     ball_x_d = (x_ext <= inc_x) ? '0 : X_W'(x_ext - inc_x);
                  end else begin
                     ball_x_d = (x_ext + inc_x >= (X_W+1)'(XMAX)) ? X_W'(XMAX)
                                                                  : X_W'(x_ext + inc_x);
                  end
               end else if (x_dir_q && x_plus >= (X_W+1)'(XMAX)) begin
                  ball_x_d  = X_W'(XMAX);
                  score_l_d = 1'b1;
                  hold_d    = '0;
                  state_d   = S_SCORED;
               end else if (!x_dir_q && x_ext <= spd_x) begin
                  ball_x_d  = '0;
                  score_r_d = 1'b1;
                  hold_d    = '0;
                  state_d   = S_SCORED;
               end else begin
                  ball_x_d = x_dir_q ? X_W'(x_plus) : X_W'(x_ext - spd_x);
               end
            end else begin
               tick_d = tick_q + TW'(1);
            end
         end
         S_SCORED: begin
            if (hold_q == HW'(HOLD_CYC - 1)) begin
               // x_dir is left untouched: it still points at the side that conceded
               state_d  = S_IDLE;
               ball_x_d = X_W'(CX);
               ball_y_d = Y_W'(CY);
               speed_d  = 3'(SPD_INIT);
               hold_d   = '0;
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         ball_x_q  <= X_W'(CX);
         ball_y_q  <= Y_W'(CY);
         x_dir_q   <= 1'b1;
         y_dir_q   <= 1'b1;
         speed_q   <= 3'(SPD_INIT);
         score_l_q <= 1'b0;
         score_r_q <= 1'b0;
         tick_q    <= '0;
         hold_q    <= '0;
         lat_l_q   <= 1'b0;
         lat_r_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         ball_x_q  <= ball_x_d;
         ball_y_q  <= ball_y_d;
         x_dir_q   <= x_dir_d;
         y_dir_q   <= y_dir_d;
         speed_q   <= speed_d;
         score_l_q <= score_l_d;
         score_r_q <= score_r_d;
         tick_q    <= tick_d;
         hold_q    <= hold_d;
         lat_l_q   <= lat_l_d;
         lat_r_q   <= lat_r_d;
      end
   end

   assign ball_x  = ball_x_q;
   assign ball_y  = ball_y_q;
   assign x_dir   = x_dir_q;
   assign y_dir   = y_dir_q;
   assign speed   = speed_q;
   assign score_l = score_l_q;
   assign score_r = score_r_q;
   assign state   = state_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed bench for ball_motion_ctrl at default parameters.
module tb_ball_motion_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       serve = 1'b0;
   logic       paddle_l_hit = 1'b0;
   logic       paddle_r_hit = 1'b0;
   logic [9:0] ball_x;
   logic [8:0] ball_y;
   logic       x_dir, y_dir, score_l, score_r;
   logic [2:0] speed;
   logic [1:0] state;

   int n_cmp = 0;
   int n_err = 0;

   ball_motion_ctrl dut (
      .clk(clk), .reset(reset), .serve(serve),
      .paddle_l_hit(paddle_l_hit), .paddle_r_hit(paddle_r_hit),
      .ball_x(ball_x), .ball_y(ball_y), .x_dir(x_dir), .y_dir(y_dir),
      .speed(speed), .score_l(score_l), .score_r(score_r), .state(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clk_n(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One motion interval: paddle inputs pulsed for one cycle mid-interval, ends just after the step edge
   task automatic interval(input logic l, input logic r);
      clk_n(1);
      paddle_l_hit = l;
      paddle_r_hit = r;
      clk_n(1);
      paddle_l_hit = 1'b0;
      paddle_r_hit = 1'b0;
      clk_n(2);
   endtask

   task automatic chk_reset_vals(input string p);
      chk({p, "_state"}, 32'(state), 0);
      chk({p, "_x"}, 32'(ball_x), 316);
      chk({p, "_y"}, 32'(ball_y), 236);
      chk({p, "_xdir"}, 32'(x_dir), 1);
      chk({p, "_ydir"}, 32'(y_dir), 1);
      chk({p, "_speed"}, 32'(speed), 1);
      chk({p, "_score_l"}, 32'(score_l), 0);
      chk({p, "_score_r"}, 32'(score_r), 0);
   endtask

   logic       hit_l[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
   int         exp_spd[4] = '{3, 4, 4, 4};
   int         exp_x[4]   = '{318, 314, 318, 314};

   initial begin
      // Asynchronous reset before any clock edge
      #2 reset = 1'b1;
      #1 chk_reset_vals("por");
      @(posedge clk);
      @(posedge clk);
      #3 reset = 1'b0;
      serve = 1'b1;
      clk_n(1);
      serve = 1'b0;
      chk("serve_state", 32'(state), 1);
      chk("serve_x", 32'(ball_x), 316);
      clk_n(3);
      chk("pre_step_x", 32'(ball_x), 316);
      clk_n(1);
      chk("step1_x", 32'(ball_x), 317);
      chk("step1_y", 32'(ball_y), 237);

      // Bottom wall at step 236, rebound at step 237
      clk_n(4 * 235);
      chk("wall_y", 32'(ball_y), 472);
      chk("wall_ydir", 32'(y_dir), 0);
      clk_n(4);
      chk("rebound_y", 32'(ball_y), 471);

      // Right miss at step 316
      clk_n(4 * 78);
      chk("pre_miss_x", 32'(ball_x), 631);
      chk("pre_miss_state", 32'(state), 1);
      clk_n(4);
      chk("miss_x", 32'(ball_x), 632);
      chk("miss_score_l", 32'(score_l), 1);
      chk("miss_score_r", 32'(score_r), 0);
      chk("miss_state", 32'(state), 2);
      clk_n(1);
      chk("pulse_end_score_l", 32'(score_l), 0);
      serve = 1'b1;
      clk_n(1);
      serve = 1'b0;
      clk_n(5);
      chk("hold_state", 32'(state), 2);
      chk("hold_x", 32'(ball_x), 632);
      clk_n(1);
      chk("idle_state", 32'(state), 0);
      chk("idle_x", 32'(ball_x), 316);
      chk("idle_y", 32'(ball_y), 236);
      chk("idle_xdir", 32'(x_dir), 1);
      chk("idle_speed", 32'(speed), 1);
      clk_n(3);
      chk("idle_stays", 32'(state), 0);

      // Paddle hits: wrong-side hit ignored, then five alternating effective hits
      serve = 1'b1;
      clk_n(1);
      serve = 1'b0;
      interval(1'b1, 1'b0);
      chk("lhit_ignored_x", 32'(ball_x), 317);
      chk("lhit_ignored_xdir", 32'(x_dir), 1);
      chk("lhit_ignored_speed", 32'(speed), 1);
      interval(1'b0, 1'b1);
      chk("rhit_x", 32'(ball_x), 315);
      chk("rhit_xdir", 32'(x_dir), 0);
      chk("rhit_speed", 32'(speed), 2);
      for (int i = 0; i < 4; i++) begin
         interval(hit_l[i], !hit_l[i]);
         chk($sformatf("hit%0d_speed", i + 2), 32'(speed), 32'(exp_spd[i]));
         chk($sformatf("hit%0d_x", i + 2), 32'(ball_x), 32'(exp_x[i]));
         chk($sformatf("hit%0d_xdir", i + 2), 32'(x_dir), 32'(hit_l[i]));
      end

      // Hit coincides with left edge condition, both latches set
      repeat (78) clk_n(4);
      chk("tie_pre_x", 32'(ball_x), 2);
      interval(1'b1, 1'b1);
      chk("tie_x", 32'(ball_x), 6);
      chk("tie_xdir", 32'(x_dir), 1);
      chk("tie_score_r", 32'(score_r), 0);
      chk("tie_state", 32'(state), 1);

      // Reset mid-MOVE between edges
      clk_n(1);
      #3 reset = 1'b1;
      #1 chk_reset_vals("arst");
      clk_n(2);
      chk("arst_hold_score_l", 32'(score_l), 0);
      chk("arst_hold_score_r", 32'(score_r), 0);
      #3 reset = 1'b0;
      serve = 1'b1;
      clk_n(1);
      serve = 1'b0;
      chk("first_serve_state", 32'(state), 1);

      // Left miss after a right-paddle return
      interval(1'b0, 1'b1);
      chk("ret_x", 32'(ball_x), 314);
      chk("ret_speed", 32'(speed), 2);
      repeat (156) clk_n(4);
      chk("lmiss_pre_x", 32'(ball_x), 2);
      clk_n(4);
      chk("lmiss_x", 32'(ball_x), 0);
      chk("lmiss_score_r", 32'(score_r), 1);
      chk("lmiss_score_l", 32'(score_l), 0);
      chk("lmiss_state", 32'(state), 2);
      clk_n(8);
      chk("lmiss_idle_state", 32'(state), 0);
      chk("lmiss_idle_xdir", 32'(x_dir), 0);
      chk("lmiss_idle_x", 32'(ball_x), 316);
      chk("lmiss_idle_speed", 32'(speed), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
